// File: rtl/banked_sram.sv
// Banked synchronous SRAM: BANKS interleaved banks, byte-enabled writes, one
// registered read response with backpressure, and a zero sweep after every reset.

module banked_sram_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 128,
  parameter int RW    = 7,
  parameter int NBYTE = WIDTH / 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [RW-1:0]    i_wrow,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [NBYTE-1:0] i_wbe,
  input  logic [RW-1:0]    i_rrow,
  output logic [WIDTH-1:0] o_rdata
);
  logic [NBYTE-1:0][7:0] r_mem [ROWS];

  // Storage carries no reset; the sweep establishes zero contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (i_wbe[b]) r_mem[i_wrow][b] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_rrow];
endmodule

module banked_sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int BANKS = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_ResetN,
  output logic                     o_InitDone,
  input  logic                     i_WrValid,
  output logic                     o_WrReady,
  input  logic [$clog2(DEPTH)-1:0] i_WrAddr,
  input  logic [WIDTH-1:0]         i_WrData,
  input  logic [WIDTH/8-1:0]       i_WrByteEn,
  input  logic                     i_RdValid,
  output logic                     o_RdReady,
  input  logic [$clog2(DEPTH)-1:0] i_RdAddr,
  output logic                     o_RdRspValid,
  input  logic                     i_RdRspReady,
  output logic [WIDTH-1:0]         o_RdRspData
);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BANKS);
  localparam int ROWS  = DEPTH / BANKS;
  localparam int NBYTE = WIDTH / 8;
  localparam int RW    = AW - BW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [RW-1:0]              r_init_row;
  logic                       r_rsp_valid;
  logic [WIDTH-1:0]           r_rsp_data;

  logic                       w_run;
  logic                       w_init_last;
  logic [BW-1:0]              w_wr_bank;
  logic [BW-1:0]              w_rd_bank;
  logic [RW-1:0]              w_wr_row;
  logic [RW-1:0]              w_rd_row;
  logic                       w_wr_fire;
  logic                       w_rd_ready;
  logic                       w_rd_fire;
  logic [RW-1:0]              w_bank_wrow;
  logic [WIDTH-1:0]           w_bank_wdata;
  logic [NBYTE-1:0]           w_bank_wbe;
  logic [BANKS-1:0]           w_bank_we;
  logic [BANKS-1:0][WIDTH-1:0] w_bank_rdata;

  assign w_run       = (r_state == S_RUN);
  assign w_init_last = (r_init_row == RW'(ROWS - 1));
  assign w_wr_bank   = i_WrAddr[BW-1:0];
  assign w_rd_bank   = i_RdAddr[BW-1:0];
  assign w_wr_row    = i_WrAddr[AW-1:BW];
  assign w_rd_row    = i_RdAddr[AW-1:BW];

  always_ff @(posedge i_Clk or negedge i_ResetN) begin
    if (!i_ResetN) r_state <= S_INIT;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (w_init_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Sweep counter parks on the last row; it does not wrap.
  always_ff @(posedge i_Clk or negedge i_ResetN) begin
    if (!i_ResetN)
      r_init_row <= '0;
    else if (!w_run && !w_init_last)
      r_init_row <= r_init_row + RW'(1);
  end

  // Writes own their bank for the cycle, so a same-bank read waits.
  assign w_wr_fire  = i_WrValid && w_run;
  assign w_rd_ready = w_run && (!r_rsp_valid || i_RdRspReady) &&
                      !(i_WrValid && (w_wr_bank == w_rd_bank));
  assign w_rd_fire  = i_RdValid && w_rd_ready;

  assign w_bank_wrow  = w_run ? w_wr_row   : r_init_row;
  assign w_bank_wdata = w_run ? i_WrData   : '0;
  assign w_bank_wbe   = w_run ? i_WrByteEn : '1;

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    assign w_bank_we[g] = !w_run || (w_wr_fire && (w_wr_bank == BW'(g)));

    banked_sram_bank #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .RW    (RW),
      .NBYTE (NBYTE)
    ) u_bank (
      .i_clk   (i_Clk),
      .i_we    (w_bank_we[g]),
      .i_wrow  (w_bank_wrow),
      .i_wdata (w_bank_wdata),
      .i_wbe   (w_bank_wbe),
      .i_rrow  (w_rd_row),
      .o_rdata (w_bank_rdata[g])
    );
  end

  always_ff @(posedge i_Clk or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rd_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_bank_rdata[w_rd_bank];
    end else if (i_RdRspReady) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_InitDone   = w_run;
  assign o_WrReady    = w_run;
  assign o_RdReady    = w_rd_ready;
  assign o_RdRspValid = r_rsp_valid;
  assign o_RdRspData  = r_rsp_data;
endmodule

// File: tb/tb_banked_sram.sv
// Self-checking bench for banked_sram: directed scenarios plus a randomized
// run against a word-array reference model.

module tb_banked_sram;
  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid;
  logic        rd_ready;
  logic [8:0]  rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] ref_mem [512];

  banked_sram dut (
    .i_Clk        (clk),
    .i_ResetN     (rst_n),
    .o_InitDone   (init_done),
    .i_WrValid    (wr_valid),
    .o_WrReady    (wr_ready),
    .i_WrAddr     (wr_addr),
    .i_WrData     (wr_data),
    .i_WrByteEn   (wr_be),
    .i_RdValid    (rd_valid),
    .o_RdReady    (rd_ready),
    .i_RdAddr     (rd_addr),
    .o_RdRspValid (rsp_valid),
    .i_RdRspReady (rsp_ready),
    .o_RdRspData  (rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    rd_valid = 0; rd_addr = 0; rsp_ready = 1;
  endtask

  // Single write, one cycle, WrReady assumed high (checked by callers where relevant).
  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1; wr_addr = 9'(a); wr_data = d; wr_be = be;
    tick();
    model_write(a, d, be);
    wr_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({init_done, wr_ready, rd_ready, rsp_valid} !== 4'b0 || rsp_data !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_values: got done/wr/rd/vld=%b data=%h required 0000 / 00000000",
               {init_done, wr_ready, rd_ready, rsp_valid}, rsp_data);
    end
    rst_n = 1;
    model_clear();
    for (int k = 1; k <= 128; k++) begin
      tick();
      compared++;
      if (init_done !== (k == 128) || wr_ready !== (k == 128) || rd_ready !== (k == 128)) begin
        mismatched++;
        $display("FAIL sweep_edge_%0d: got done/wr/rd=%b%b%b required %0d for all",
                 k, init_done, wr_ready, rd_ready, (k == 128));
      end
    end
    // Stream every address and expect zero, back to back.
    for (int i = 0; i < 512; i++) begin
      rd_valid = 1; rd_addr = 9'(i);
      #1;
      compared++;
      if (rd_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL zero_rd_ready_%0d: got %b required 1", i, rd_ready);
      end
      tick();
      compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[i]) begin
        mismatched++;
        $display("FAIL zero_read_%0d: got vld=%b data=%h required 1 %h", i, rsp_valid, rsp_data, ref_mem[i]);
      end
    end
    rd_valid = 0;
    tick();
  endtask

  task automatic test_byte_en();
    wr_valid = 1; wr_addr = 5; wr_data = 32'h11223344; wr_be = 4'b1111;
    #1;
    compared++;
    if (wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL be_wr_ready: got %b required 1", wr_ready);
    end
    do_write(5, 32'h11223344, 4'b1111);
    do_write(5, 32'hAABBCCDD, 4'b0101);
    do_write(5, 32'h99999999, 4'b0000);
    rd_valid = 1; rd_addr = 5;
    tick();
    rd_valid = 0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h11BB33DD) begin
      mismatched++;
      $display("FAIL byte_enable: got vld=%b data=%h required 1 11bb33dd", rsp_valid, rsp_data);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL be_rsp_drop: got %b required 0", rsp_valid);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    d = $urandom;
    wr_valid = 1; wr_addr = 8; wr_data = d; wr_be = 4'hF;
    rd_valid = 1; rd_addr = 12;
    #1;
    compared++;
    if (rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL conflict_stall: got rd=%b wr=%b required 0 1", rd_ready, wr_ready);
    end
    tick();
    model_write(8, d, 4'hF);
    wr_valid = 0;
    #1;
    compared++;
    if (rd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL conflict_release: got %b required 1", rd_ready);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[12]) begin
      mismatched++;
      $display("FAIL conflict_read12: got vld=%b data=%h required 1 %h", rsp_valid, rsp_data, ref_mem[12]);
    end
    rd_addr = 8;
    tick();
    compared++;
    if (rsp_data !== ref_mem[8]) begin
      mismatched++;
      $display("FAIL conflict_write8: got %h required %h", rsp_data, ref_mem[8]);
    end
    d = $urandom;
    wr_valid = 1; wr_addr = 8; wr_data = d; rd_addr = 9;
    #1;
    compared++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL diff_bank_ready: got rd=%b wr=%b required 1 1", rd_ready, wr_ready);
    end
    tick();
    model_write(8, d, 4'hF);
    wr_valid = 0; rd_addr = 8;
    compared++;
    if (rsp_data !== ref_mem[9]) begin
      mismatched++;
      $display("FAIL diff_bank_read9: got %h required %h", rsp_data, ref_mem[9]);
    end
    tick();
    rd_valid = 0;
    compared++;
    if (rsp_data !== d) begin
      mismatched++;
      $display("FAIL diff_bank_write8: got %h required %h", rsp_data, d);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_write(3, 32'hDEADBEEF, 4'hF);
    do_write(4, $urandom, 4'hF);
    rsp_ready = 0; rd_valid = 1; rd_addr = 3;
    tick();
    rd_addr = 4;
    for (int c = 0; c < 5; c++) begin
      #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rd_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL backpressure_hold_%0d: got vld=%b data=%h rdy=%b required 1 deadbeef 0",
                 c, rsp_valid, rsp_data, rd_ready);
      end
      tick();
    end
    rsp_ready = 1;
    #1;
    compared++;
    if (rd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure_release: got %b required 1", rd_ready);
    end
    tick();
    rd_valid = 0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[4]) begin
      mismatched++;
      $display("FAIL backpressure_next: got vld=%b data=%h required 1 %h", rsp_valid, rsp_data, ref_mem[4]);
    end
    tick();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 16; i++) do_write(i, $urandom, 4'hF);
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1; rd_addr = 9'(i);
      tick();
      compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[i]) begin
        mismatched++;
        $display("FAIL stream_%0d: got vld=%b data=%h required 1 %h", i, rsp_valid, rsp_data, ref_mem[i]);
      end
    end
    rd_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_rdy;
    int          wa, ra;
    exp_valid = 0;
    exp_data  = 0;
    for (int n = 0; n < 400; n++) begin
      wa = $urandom_range(0, 63);
      ra = $urandom_range(0, 63);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr = 9'(wa); wr_data = $urandom; wr_be = 4'($urandom);
      rd_valid = ($urandom_range(0, 1) == 0);
      rd_addr = 9'(ra);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      // A read waits if the response slot is occupied or its bank is being written.
      exp_rdy = (!exp_valid || rsp_ready) && !(wr_valid && (wa % 4) == (ra % 4));
      compared++;
      if (rd_ready !== exp_rdy) begin
        mismatched++;
        $display("FAIL rand_rd_ready_%0d: got %b required %b", n, rd_ready, exp_rdy);
      end
      tick();
      if (rd_valid && exp_rdy) begin
        exp_valid = 1; exp_data = ref_mem[ra];
      end else if (rsp_ready) begin
        exp_valid = 0;
      end
      if (wr_valid) model_write(wa, wr_data, wr_be);
      compared++;
      if (rsp_valid !== exp_valid || (exp_valid && rsp_data !== exp_data)) begin
        mismatched++;
        $display("FAIL rand_rsp_%0d: got vld=%b data=%h required %b %h", n, rsp_valid, rsp_data, exp_valid, exp_data);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_mid_reset();
    do_write(7, 32'hFFFFFFFF, 4'hF);
    rsp_ready = 0; rd_valid = 1; rd_addr = 7;
    tick();
    rd_valid = 0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL midrst_stalled: got vld=%b data=%h required 1 ffffffff", rsp_valid, rsp_data);
    end
    #2 rst_n = 0;
    #1;
    compared++;
    if ({init_done, wr_ready, rd_ready, rsp_valid} !== 4'b0 || rsp_data !== 32'h0) begin
      mismatched++;
      $display("FAIL midrst_async_clear: got done/wr/rd/vld=%b data=%h required 0000 / 00000000",
               {init_done, wr_ready, rd_ready, rsp_valid}, rsp_data);
    end
    tick();
    rst_n = 1;
    rsp_ready = 1;
    model_clear();
    for (int k = 1; k <= 128; k++) begin
      tick();
      compared++;
      if (init_done !== (k == 128)) begin
        mismatched++;
        $display("FAIL midrst_sweep_%0d: got %b required %0d", k, init_done, (k == 128));
      end
    end
    rd_valid = 1; rd_addr = 7;
    tick();
    rd_valid = 0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[7]) begin
      mismatched++;
      $display("FAIL midrst_read7: got vld=%b data=%h required 1 %h", rsp_valid, rsp_data, ref_mem[7]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_conflict();
    test_backpressure();
    test_streaming();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
